// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared register-file definitions for the write-back arbiter and its FIFO:
// address/data bus types, enable/reset polarities, the default secondary
// FIFO depth, the FIFO entry type and a helper that qualifies a destination
// register (r0 is hard-wired and never written).
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

  localparam int RegNumLog2  = 5;
  localparam int RegW        = 32;
  localparam int WbFifoDepth = 4;

  typedef logic [RegNumLog2-1:0] RegAddrBus;
  typedef logic [RegW-1:0]       RegBus;

  localparam RegBus ZeroWord     = '0;
  localparam logic  WriteEnable  = 1'b1;
  localparam logic  WriteDisable = 1'b0;
  localparam logic  RstEnable    = 1'b1;
  localparam logic  RstDisable   = 1'b0;

  typedef struct packed {
    RegAddrBus wadd;
    RegBus     wdata;
  } wb_entry_t;

  // A write to r0 is architecturally a no-op, so it never counts as a request.
  function automatic logic is_valid_addr(input RegAddrBus a);
    return (a != '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// In-order synchronous FIFO holding queued secondary write-backs as
// {wadd, wdata}. A separate occupancy count distinguishes full from empty so
// the read/write pointers can wrap naturally. Two address comparators report
// whether any occupied slot targets a given register (for decode hazards).
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset (pointers/count only)
//   i_push      in   write i_entry at the tail (ignored when full)
//   i_entry     in   entry to push
//   i_pop       in   drop the head entry (ignored when empty)
//   o_head      out  current head entry
//   o_full      out  count == DEPTH
//   o_empty     out  count == 0
//   i_chk_add1  in   register address to look up (port 1)
//   i_chk_add2  in   register address to look up (port 2)
//   o_match1    out  an occupied slot targets i_chk_add1 (never for r0)
//   o_match2    out  an occupied slot targets i_chk_add2 (never for r0)
// ---------------------------------------------------------------------------
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = WbFifoDepth,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty,
  input  RegAddrBus i_chk_add1,
  input  RegAddrBus i_chk_add2,
  output logic      o_match1,
  output logic      o_match2
);

  wb_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: slots are only ever read once the count says
  // they are occupied.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [AW-1:0] w_off;
    logic          w_vld;
    assign w_off     = AW'(g) - r_rd_ptr;
    assign w_vld     = ({1'b0, w_off} < r_count);
    assign w_hit1[g] = w_vld && (r_mem[g].wadd == i_chk_add1);
    assign w_hit2[g] = w_vld && (r_mem[g].wadd == i_chk_add2);
  end

  assign o_match1 = is_valid_addr(i_chk_add1) && (|w_hit1);
  assign o_match2 = is_valid_addr(i_chk_add2) && (|w_hit2);

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Drives the register file's single write port from two sources: the
// in-order pipeline (always wins, never back-pressured) and a secondary
// multi-cycle source (valid/ready) that always goes through an in-order FIFO.
// Decode can query whether a queued write targets a register it wants to read.
//
// Optional build macro: WB_STARVE_GUARD_EN enables a starvation counter that
// raises stall_req after STARVE_MAX consecutive cycles in which a queued
// entry could not be written. Without it stall_req is tied low.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   p_wen/p_wadd/p_wdata pipeline write request (p_wadd == 0 is no request)
//   s_valid/s_ready     secondary handshake; s_wadd/s_wdata its payload
//   w_en/w_add/w_data   registered register-file write port
//   chk_add1/chk_add2   decode read addresses to check
//   chk_busy1/chk_busy2 a queued write targets the matching chk_add
//   stall_req           starvation stall request to pipeline control
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = WbFifoDepth,
  parameter int STARVE_MAX = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      p_wen,
  input  RegAddrBus p_wadd,
  input  RegBus     p_wdata,
  input  logic      s_valid,
  output logic      s_ready,
  input  RegAddrBus s_wadd,
  input  RegBus     s_wdata,
  output logic      w_en,
  output RegAddrBus w_add,
  output RegBus     w_data,
  input  RegAddrBus chk_add1,
  input  RegAddrBus chk_add2,
  output logic      chk_busy1,
  output logic      chk_busy2,
  output logic      stall_req
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (STARVE_MAX < 1)) begin : g_bad_param
    $error("wb_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_MAX >= 1");
  end

  logic      w_run;
  logic      w_p_req;
  logic      w_s_ready;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;
  logic      w_match1;
  logic      w_match2;
  wb_entry_t w_head;
  wb_entry_t w_s_entry;

  logic      r_w_en_p1;
  RegAddrBus r_w_add_p1;
  RegBus     r_w_data_p1;

  // ---- stage p0: request qualification and arbitration ----
  assign w_run     = (rst == RstDisable);
  assign w_p_req   = p_wen && is_valid_addr(p_wadd);
  // Readiness looks only at the current count; a same-cycle pop does not
  // make room, which keeps s_ready free of any path from p_wen.
  assign w_s_ready = w_run && !w_full;
  assign w_push    = s_valid && w_s_ready && is_valid_addr(s_wadd);
  assign w_pop     = w_run && !w_p_req && !w_empty;
  assign w_s_entry = '{wadd: s_wadd, wdata: s_wdata};

  assign s_ready   = w_s_ready;
  assign chk_busy1 = w_run && w_match1;
  assign chk_busy2 = w_run && w_match2;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_entry    (w_s_entry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .i_chk_add1 (chk_add1),
    .i_chk_add2 (chk_add2),
    .o_match1   (w_match1),
    .o_match2   (w_match2)
  );

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_w_en_p1   <= WriteDisable;
      r_w_add_p1  <= '0;
      r_w_data_p1 <= ZeroWord;
    end else if (w_p_req) begin
      r_w_en_p1   <= WriteEnable;
      r_w_add_p1  <= p_wadd;
      r_w_data_p1 <= p_wdata;
    end else if (w_pop) begin
      r_w_en_p1   <= WriteEnable;
      r_w_add_p1  <= w_head.wadd;
      r_w_data_p1 <= w_head.wdata;
    end else begin
      r_w_en_p1   <= WriteDisable;
    end
  end

  assign w_en   = r_w_en_p1;
  assign w_add  = r_w_add_p1;
  assign w_data = r_w_data_p1;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve_cnt;
  logic          r_stall_p1;

  // The counter sits at STARVE_MAX until the head is finally popped, so the
  // stall request stays up for exactly as long as the starvation lasts.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_starve_cnt <= '0;
      r_stall_p1   <= 1'b0;
    end else begin
      if (w_pop || w_empty) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end
      r_stall_p1 <= !w_pop && (r_starve_cnt == SW'(STARVE_MAX));
    end
  end

  assign stall_req = r_stall_p1;
`else
  assign stall_req = 1'b0;
`endif

endmodule
